// File: rtl/steer_pkg.sv
// Shared constants for the steering quadrature stepper: Gray-coded phase
// encoding, the default step period, and the phase advance helper.
package steer_pkg;

   localparam logic [1:0] PH0 = 2'b00;
   localparam logic [1:0] PH1 = 2'b01;
   localparam logic [1:0] PH2 = 2'b11;
   localparam logic [1:0] PH3 = 2'b10;

   localparam int CLKDIV_DEF = 22500;

   // Forward walks PH0->PH1->PH2->PH3->PH0; reverse walks the same ring backwards.
   function automatic logic [1:0] ph_next(input logic [1:0] ph, input logic up);
      logic [1:0] nxt;
      nxt = PH0;
      case (ph)
         PH0: nxt = up ? PH1 : PH3;
         PH1: nxt = up ? PH2 : PH0;
         PH2: nxt = up ? PH3 : PH1;
         PH3: nxt = up ? PH0 : PH2;
         default: nxt = PH0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/steer_tick_div.sv
// Step-period timer: counts 0..CLKDIV-1 while enabled, parks at 0 otherwise,
// and flags the terminal-count cycle as tick.
module steer_tick_div
   import steer_pkg::*;
#(
   parameter int CLKDIV = CLKDIV_DEF
) (
   input  logic CLK,
   input  logic Reset_n,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(CLKDIV);
   localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/steer_delta_quad.sv
// Accumulates signed steering deltas and pays them out one quadrature step
// per tick, saturating the pending count and flagging any clamp.
module steer_delta_quad
   import steer_pkg::*;
#(
   parameter int DELTA_W = 8,
   parameter int ACC_W   = 10,
   parameter int CLKDIV  = CLKDIV_DEF
) (
   input  logic                      CLK,
   input  logic                      Reset_n,
   input  logic                      delta_valid,
   input  logic signed [DELTA_W-1:0] delta,
   input  logic                      enable,
   input  logic                      flush,
   input  logic                      clr_ovf,
   output logic [1:0]                steer,
   output logic signed [ACC_W-1:0]   pending,
   output logic                      busy,
   output logic                      overflow
);

   // One guard bit is enough: |delta| <= 2^(ACC_W-2) because ACC_W > DELTA_W.
   localparam int SW = ACC_W + 1;

   logic                    tick;
   logic [1:0]              steer_q, steer_d;
   logic signed [ACC_W-1:0] pending_q, pending_d;
   logic                    ovf_q, ovf_d;
   logic                    do_step, step_up, clamp;
   logic signed [SW-1:0]    delta_ext, dir_ext, sum;

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
      logic signed [ACC_W-1:0] r;
      r = v[ACC_W-1:0];
      if (v[SW-1] != v[SW-2]) begin
         r = v[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      return r;
   endfunction

   steer_tick_div #(
      .CLKDIV (CLKDIV)
   ) u_tick (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .enable  (enable),
      .tick    (tick)
   );

   // Step decision looks only at the registered count, never the incoming delta.
   always_comb begin
      do_step   = tick && (pending_q != '0) && !flush;
      step_up   = !pending_q[ACC_W-1];
      delta_ext = delta_valid ? $signed({{(SW-DELTA_W){delta[DELTA_W-1]}}, delta}) : '0;
      dir_ext   = '0;
      if (do_step) begin
         dir_ext = step_up ? SW'(1) : '1;
      end
      sum   = $signed({pending_q[ACC_W-1], pending_q}) + delta_ext - dir_ext;
      clamp = !flush && (sum[SW-1] != sum[SW-2]);

      steer_d   = do_step ? ph_next(steer_q, step_up) : steer_q;
      pending_d = flush ? '0 : sat_acc(sum);
      ovf_d     = clamp || (ovf_q && !clr_ovf);
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         steer_q   <= PH0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         steer_q   <= steer_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign steer    = steer_q;
   assign pending  = pending_q;
   assign busy     = (pending_q != '0);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_steer_delta_quad.sv
// Directed scenarios plus a randomized run of steer_delta_quad, checked every
// cycle against an integer model of the accumulator, ring position and timer.
module tb_steer_delta_quad;

   localparam int DW   = 8;
   localparam int AW   = 10;
   localparam int CD   = 4;
   localparam int PMAX = (1 << (AW - 1)) - 1;
   localparam int PMIN = -(1 << (AW - 1));

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 dv = 1'b0;
   logic signed [DW-1:0] d = '0;
   logic                 en = 1'b0;
   logic                 fl = 1'b0;
   logic                 co = 1'b0;
   logic [1:0]           steer;
   logic signed [AW-1:0] pending;
   logic                 busy;
   logic                 ovf;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state: pending count, ring position 0..3, timer count, sticky flag.
   int mp   = 0;
   int mpos = 0;
   int mtmr = 0;
   int mo   = 0;

   always #5 clk = ~clk;

   steer_delta_quad #(
      .DELTA_W (DW),
      .ACC_W   (AW),
      .CLKDIV  (CD)
   ) dut (
      .CLK         (clk),
      .Reset_n     (rst_n),
      .delta_valid (dv),
      .delta       (d),
      .enable      (en),
      .flush       (fl),
      .clr_ovf     (co),
      .steer       (steer),
      .pending     (pending),
      .busy        (busy),
      .overflow    (ovf)
   );

   function automatic logic [1:0] ring_code(input int pos);
      logic [1:0] c;
      case (pos)
         0: c = 2'b00;
         1: c = 2'b01;
         2: c = 2'b11;
         default: c = 2'b10;
      endcase
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".steer"},   32'(steer), 32'(ring_code(mpos)));
      check({tag, ".pending"}, 32'($signed(pending)), mp);
      check({tag, ".busy"},    32'(busy), 32'(mp != 0));
      check({tag, ".ovf"},     32'(ovf), mo);
   endtask

   task automatic model_reset();
      mp   = 0;
      mpos = 0;
      mtmr = 0;
      mo   = 0;
   endtask

   task automatic model_edge();
      int dir, s;
      bit tick, clamp;
      tick  = en && (mtmr == CD - 1);
      dir   = 0;
      clamp = 0;
      if (tick && mp != 0 && !fl) dir = (mp > 0) ? 1 : -1;
      mpos = (mpos + dir + 4) % 4;
      mtmr = en ? (mtmr + 1) % CD : 0;
      if (fl) begin
         mp = 0;
      end else begin
         s = mp + (dv ? int'(d) : 0) - dir;
         if (s > PMAX) begin s = PMAX; clamp = 1; end
         if (s < PMIN) begin s = PMIN; clamp = 1; end
         mp = s;
      end
      if (clamp) mo = 1;
      else if (co) mo = 0;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic idle();
      dv = 1'b0;
      d  = '0;
      fl = 1'b0;
      co = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance with current inputs until the model says the coming edge is a tick edge.
   task automatic to_tick_cycle();
      for (int i = 0; i < CD && mtmr != CD - 1; i++) cyc("align");
   endtask

   initial begin
      idle();
      en = 1'b0;
      do_reset();

      // Positive: +3 pays out as three forward steps, four clocks apart.
      en = 1'b1; dv = 1'b1; d = 8'sd3;
      cyc("pos.load");
      idle();
      repeat (3) cyc("pos.run");
      check("pos.step1.steer", 32'(steer), 32'(2'b01));
      check("pos.step1.pending", 32'($signed(pending)), 2);
      repeat (4) cyc("pos.run");
      check("pos.step2.steer", 32'(steer), 32'(2'b11));
      repeat (4) cyc("pos.run");
      check("pos.step3.steer", 32'(steer), 32'(2'b10));
      check("pos.step3.busy", 32'(busy), 0);

      // Negative: -2 walks the ring backwards from 00.
      en = 1'b0;
      do_reset();
      en = 1'b1; dv = 1'b1; d = -8'sd2;
      cyc("neg.load");
      idle();
      repeat (3) cyc("neg.run");
      check("neg.step1.steer", 32'(steer), 32'(2'b10));
      repeat (4) cyc("neg.run");
      check("neg.step2.steer", 32'(steer), 32'(2'b11));
      check("neg.step2.pending", 32'($signed(pending)), 0);

      // Saturation: preload 500 with stepping disabled, then push past the top.
      en = 1'b0; dv = 1'b1;
      d = 8'sd127; cyc("sat.load");
      cyc("sat.load");
      cyc("sat.load");
      d = 8'sd119; cyc("sat.load");
      check("sat.preload", 32'($signed(pending)), 500);
      d = 8'sd100; cyc("sat.clamp");
      check("sat.pending", 32'($signed(pending)), 511);
      check("sat.ovf", 32'(ovf), 1);
      idle(); co = 1'b1;
      cyc("sat.clr");
      check("sat.clr.ovf", 32'(ovf), 0);
      check("sat.clr.pending", 32'($signed(pending)), 511);
      // Clear and new clamp together leave the flag set.
      co = 1'b1; dv = 1'b1; d = 8'sd50;
      cyc("sat.clr_and_clamp");
      check("sat.clr_and_clamp.ovf", 32'(ovf), 1);
      idle();

      // Flush on a tick with a same-cycle delta, pending=4.
      do_reset();
      en = 1'b0; dv = 1'b1; d = 8'sd4;
      cyc("flush.load");
      idle(); en = 1'b1;
      to_tick_cycle();
      fl = 1'b1; dv = 1'b1; d = 8'sd7;
      cyc("flush.tick");
      check("flush.pending", 32'($signed(pending)), 0);
      check("flush.steer", 32'(steer), 32'(2'b00));
      idle();

      // Disabled: accumulate without stepping, then release.
      en = 1'b0; dv = 1'b1; d = 8'sd2;
      cyc("dis.load");
      idle();
      repeat (6) cyc("dis.hold");
      check("dis.pending", 32'($signed(pending)), 2);
      check("dis.steer", 32'(steer), 32'(2'b00));
      en = 1'b1;
      repeat (CD) cyc("dis.release");
      check("dis.release.steer", 32'(steer), 32'(2'b01));
      check("dis.release.pending", 32'($signed(pending)), 1);

      // Simultaneous: pending=1 plus +1 on a tick steps once and stays at 1.
      to_tick_cycle();
      dv = 1'b1; d = 8'sd1;
      cyc("sim.step");
      check("sim.step.steer", 32'(steer), 32'(2'b11));
      check("sim.step.pending", 32'($signed(pending)), 1);
      idle(); fl = 1'b1;
      cyc("sim.flush");
      idle();
      // pending=0 plus +5 on a tick: no step on that tick.
      to_tick_cycle();
      dv = 1'b1; d = 8'sd5;
      cyc("sim.nostep");
      check("sim.nostep.steer", 32'(steer), 32'(2'b11));
      check("sim.nostep.pending", 32'($signed(pending)), 5);
      idle();

      // Reset mid-operation with pending=9, steer=11.
      do_reset();
      en = 1'b1; dv = 1'b1; d = 8'sd11;
      cyc("mid.load");
      idle();
      repeat (7) cyc("mid.run");
      check("mid.pre.steer", 32'(steer), 32'(2'b11));
      check("mid.pre.pending", 32'($signed(pending)), 9);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid.steer", 32'(steer), 32'(2'b00));
      check("mid.pending", 32'($signed(pending)), 0);
      check("mid.ovf", 32'(ovf), 0);
      check("mid.busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      // After release the first step lands CD edges after the first enabled edge.
      dv = 1'b1; d = 8'sd1;
      cyc("rel.load");
      idle();
      repeat (CD - 2) cyc("rel.wait");
      check("rel.nostep.steer", 32'(steer), 32'(2'b00));
      cyc("rel.step");
      check("rel.step.steer", 32'(steer), 32'(2'b01));

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         dv = 1'($urandom_range(0, 1));
         d  = DW'($urandom);
         en = ($urandom_range(0, 7) != 0);
         fl = ($urandom_range(0, 40) == 0);
         co = ($urandom_range(0, 15) == 0);
         cyc("rand");
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
